// File: rtl/ccgrcg_pkg.sv
// rtl/ccgrcg_pkg.sv - shared layer/expansion functions and mode constants for ccgrcg_pipe
package ccgrcg_pkg;

    // Functions work on a fixed-width carrier; callers pass their real width w (< MAX_W).
    localparam int MAX_W  = 256;
    localparam int IDX_W  = 8;
    localparam int SEQ_OFF = 0;
    localparam int SEQ_ON  = 1;

    function automatic logic [MAX_W-1:0] layer_f(input logic [MAX_W-1:0] s, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                r[IDX_W'(i)] = s[IDX_W'(i)] ^ (s[IDX_W'((i + 1) % w)] & ~s[IDX_W'((i + 2) % w)]);
            end
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] expand_in(input logic [MAX_W-1:0] x, input int nin, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                r[IDX_W'(i)] = x[IDX_W'(i % nin)] ^ (((i / nin) % 2) == 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ccgrcg_stage.sv
// rtl/ccgrcg_stage.sv - one elastic register slice applying the layer function
module ccgrcg_stage
    import ccgrcg_pkg::*;
#(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv_next,
    output logic         adv,
    input  logic         v_in,
    input  logic [W-1:0] d_in,
    output logic         v,
    output logic [W-1:0] d
);

    logic [MAX_W-1:0] l_full;
    logic             unused_hi;

    assign l_full    = layer_f(MAX_W'(d_in), W);
    assign unused_hi = ^l_full[MAX_W-1:W];

    // An empty slice can always take new data, even while downstream stalls.
    assign adv = ~v | adv_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            d <= '0;
        end else if (adv) begin
            v <= v_in;
            if (v_in) begin
                d <= l_full[W-1:0];
            end
        end
    end

endmodule

// File: rtl/ccgrcg_pipe.sv
// rtl/ccgrcg_pipe.sv - pipelined random-logic mapper with elastic handshake and optional accumulator
module ccgrcg_pipe
    import ccgrcg_pkg::*;
#(
    parameter int NUM_IN   = 5,
    parameter int NUM_OUT  = 19,
    parameter int STAGES   = 3,
    parameter int SEQ_MODE = 0,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUM_IN-1:0]  x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] f,
    output logic [CNT_W-1:0]   out_count
);

    localparam int W = NUM_OUT;

    logic [MAX_W-1:0] s0_full;
    logic [W-1:0]     s0;
    logic             unused_s0;
    logic [W-1:0]     d_last;
    logic             xfer;

    assign s0_full   = expand_in(MAX_W'(x), NUM_IN, W);
    assign s0        = s0_full[W-1:0];
    assign unused_s0 = ^s0_full[MAX_W-1:W];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic         v_in_c;
        logic [W-1:0] d_in_c;
        logic         adv_next_c;
        logic         adv_c;
        logic         v_q;
        logic [W-1:0] d_q;

        if (k == 0) begin : g_first
            assign v_in_c = in_valid;
            assign d_in_c = s0;
        end else begin : g_next
            assign v_in_c = g_stage[k-1].v_q;
            assign d_in_c = g_stage[k-1].d_q;
        end

        if (k == STAGES - 1) begin : g_last
            assign adv_next_c = out_ready;
        end else begin : g_mid
            assign adv_next_c = g_stage[k+1].adv_c;
        end

        ccgrcg_stage #(.W(W)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .adv_next (adv_next_c),
            .adv      (adv_c),
            .v_in     (v_in_c),
            .d_in     (d_in_c),
            .v        (v_q),
            .d        (d_q)
        );
    end

    assign in_ready  = g_stage[0].adv_c;
    assign out_valid = g_stage[STAGES-1].v_q;
    assign d_last    = g_stage[STAGES-1].d_q;
    assign xfer      = out_valid & out_ready;

    if (SEQ_MODE == SEQ_ON) begin : g_acc
        logic [W-1:0] acc;
        assign f = d_last ^ acc;
        always_ff @(posedge clk) begin
            if (rst) begin
                acc <= '0;
            end else if (xfer) begin
                acc <= f;
            end
        end
    end else begin : g_noacc
        assign f = d_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_count <= '0;
        end else if (xfer) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ccgrcg_pipe.sv
// tb/tb_ccgrcg_pipe.sv - self-checking bench for ccgrcg_pipe across several configurations
module tb_ccgrcg_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        a_iv, a_ir, a_ov, a_or;
    logic [3:0]  a_x, a_f;
    logic [15:0] a_cnt;
    logic        b_iv, b_ir, b_ov, b_or;
    logic [3:0]  b_x, b_f;
    logic [15:0] b_cnt;
    logic        c_iv, c_ir, c_ov, c_or;
    logic [4:0]  c_x;
    logic [18:0] c_f;
    logic [15:0] c_cnt;
    logic        d_iv, d_ir, d_ov, d_or;
    logic [4:0]  d_x;
    logic [18:0] d_f;
    logic [3:0]  d_cnt;

    ccgrcg_pipe #(.NUM_IN(4), .NUM_OUT(4), .STAGES(1), .SEQ_MODE(0), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .x(a_x),
        .out_valid(a_ov), .out_ready(a_or), .f(a_f), .out_count(a_cnt));
    ccgrcg_pipe #(.NUM_IN(4), .NUM_OUT(4), .STAGES(1), .SEQ_MODE(1), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .x(b_x),
        .out_valid(b_ov), .out_ready(b_or), .f(b_f), .out_count(b_cnt));
    ccgrcg_pipe #(.NUM_IN(5), .NUM_OUT(19), .STAGES(3), .SEQ_MODE(0), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .x(c_x),
        .out_valid(c_ov), .out_ready(c_or), .f(c_f), .out_count(c_cnt));
    ccgrcg_pipe #(.NUM_IN(5), .NUM_OUT(19), .STAGES(3), .SEQ_MODE(1), .CNT_W(4)) u_d (
        .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .x(d_x),
        .out_valid(d_ov), .out_ready(d_or), .f(d_f), .out_count(d_cnt));

    // Bit-list model: expand the input, then apply the layer rule once per stage.
    function automatic logic [31:0] model_map(input logic [31:0] xv, input int nin, input int w, input int stages);
        bit s[$];
        bit t[$];
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            s.push_back(bit'(((xv >> (i % nin)) ^ 32'((i / nin) % 2)) & 32'd1));
        end
        for (int k = 0; k < stages; k++) begin
            t = {};
            for (int i = 0; i < w; i++) begin
                t.push_back(s[i] ^ (s[(i + 1) % w] & ~s[(i + 2) % w]));
            end
            s = t;
        end
        for (int i = 0; i < w; i++) begin
            r = r | ({31'b0, s[i]} << i);
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        a_iv = 0; a_or = 1; a_x = '0;
        b_iv = 0; b_or = 1; b_x = '0;
        c_iv = 0; c_or = 1; c_x = '0;
        d_iv = 0; d_or = 1; d_x = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL reset_a_out_valid got %b want 0", a_ov); end
        n_cmp++; if (a_ir !== 1'b1) begin n_bad++; $display("FAIL reset_a_in_ready got %b want 1", a_ir); end
        n_cmp++; if (a_f !== 4'h0) begin n_bad++; $display("FAIL reset_a_f got %h want 0", a_f); end
        n_cmp++; if (c_ov !== 1'b0 || c_ir !== 1'b1) begin n_bad++; $display("FAIL reset_c_handshake got ov=%b ir=%b want 0/1", c_ov, c_ir); end
        n_cmp++; if (c_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_c_count got %0d want 0", c_cnt); end
        n_cmp++; if (d_f !== 19'd0 || d_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_d_f_count got f=%h cnt=%0d want 0/0", d_f, d_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        a_x = 4'b0001; a_iv = 1; a_or = 1;
        @(negedge clk);
        n_cmp++; if (a_ov !== 1'b1 || a_f !== 4'h9) begin n_bad++; $display("FAIL basic_map got ov=%b f=%h want 1/9", a_ov, a_f); end
        a_x = 4'hF;
        @(negedge clk);
        n_cmp++; if (a_f !== 4'hF) begin n_bad++; $display("FAIL all_ones got %h want f", a_f); end
        n_cmp++; if (a_cnt !== 16'd1) begin n_bad++; $display("FAIL basic_count1 got %0d want 1", a_cnt); end
        a_iv = 0;
        @(negedge clk);
        n_cmp++; if (a_ov !== 1'b0 || a_cnt !== 16'd2) begin n_bad++; $display("FAIL basic_drain got ov=%b cnt=%0d want 0/2", a_ov, a_cnt); end
    endtask

    task automatic test_seq();
        logic [3:0] exp_f [3] = '{4'h9, 4'h0, 4'h9};
        b_x = 4'b0001; b_iv = 1; b_or = 1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_cmp++; if (b_ov !== 1'b1 || b_f !== exp_f[j]) begin n_bad++; $display("FAIL seq_f%0d got ov=%b f=%h want 1/%h", j, b_ov, b_f, exp_f[j]); end
            if (j == 2) b_iv = 0;
        end
        @(negedge clk);
        n_cmp++; if (b_cnt !== 16'd3) begin n_bad++; $display("FAIL seq_count got %0d want 3", b_cnt); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got = 0;
        logic [18:0] q[$];
        logic [18:0] exp_f;
        logic [18:0] hold_f = '0;
        logic [4:0]  cur;
        bit stalled = 0;
        bit saw_full = 0;
        logic exp_ir;
        cur = 5'($urandom);
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            c_or = !(cyc >= 4 && cyc <= 7);
            c_iv = (sent < 8);
            c_x  = cur;
            #1;
            exp_ir = c_or || ((sent - got) < 3);
            n_cmp++; if (c_ir !== exp_ir) begin n_bad++; $display("FAIL bp_in_ready cyc%0d got %b want %b", cyc, c_ir, exp_ir); end
            if (!c_ir) saw_full = 1;
            if (c_ov && !c_or) begin
                if (stalled) begin
                    n_cmp++; if (c_f !== hold_f) begin n_bad++; $display("FAIL bp_stall_stable cyc%0d got %h want %h", cyc, c_f, hold_f); end
                end
                hold_f = c_f;
                stalled = 1;
            end else begin
                stalled = 0;
            end
            if (c_ov && c_or) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL bp_spurious cyc%0d got f=%h want no output", cyc, c_f);
                end else begin
                    exp_f = q.pop_front();
                    n_cmp++; if (c_f !== exp_f) begin n_bad++; $display("FAIL bp_out%0d got %h want %h", got, c_f, exp_f); end
                end
                got++;
            end
            if (c_iv && c_ir) begin
                q.push_back(19'(model_map(32'(cur), 5, 19, 3)));
                sent++;
                cur = 5'($urandom);
            end
        end
        c_iv = 0;
        n_cmp++; if (saw_full !== 1'b1) begin n_bad++; $display("FAIL bp_backpressure got in_ready never low want low when 3 held"); end
        n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL bp_out_total got %0d want 8", got); end
        @(negedge clk);
        n_cmp++; if (c_cnt !== 16'd8) begin n_bad++; $display("FAIL bp_count got %0d want 8", c_cnt); end
    endtask

    task automatic test_reset_mid();
        bit stale = 0;
        c_or = 0; c_iv = 1;
        for (int j = 0; j < 2; j++) begin
            c_x = 5'($urandom);
            @(negedge clk);
        end
        c_iv = 0; rst = 1;
        @(negedge clk);
        n_cmp++; if (c_ov !== 1'b0 || c_cnt !== 16'd0 || c_ir !== 1'b1) begin n_bad++; $display("FAIL rst_mid got ov=%b cnt=%0d ir=%b want 0/0/1", c_ov, c_cnt, c_ir); end
        rst = 0; c_or = 1;
        b_x = 4'b0001; b_iv = 1; b_or = 1;
        @(negedge clk);
        n_cmp++; if (b_ov !== 1'b1 || b_f !== 4'h9) begin n_bad++; $display("FAIL rst_acc_clear got ov=%b f=%h want 1/9", b_ov, b_f); end
        b_iv = 0;
        if (c_ov) stale = 1;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (c_ov) stale = 1;
        end
        n_cmp++; if (stale !== 1'b0) begin n_bad++; $display("FAIL rst_stale got out_valid after reset want none"); end
    endtask

    task automatic test_random_wrap();
        int sent = 0;
        int got = 0;
        logic [18:0] q[$];
        logic [18:0] acc_m = '0;
        logic [18:0] exp_f;
        logic [4:0]  cur;
        cur = 5'($urandom);
        for (int cyc = 0; cyc < 400 && got < 17; cyc++) begin
            @(negedge clk);
            d_or = ($urandom_range(0, 3) != 0);
            if (!(d_iv && !d_ir)) d_iv = (sent < 17) && ($urandom_range(0, 3) != 0);
            d_x = cur;
            #1;
            if (d_ov && d_or) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL wrap_spurious cyc%0d got f=%h want no output", cyc, d_f);
                end else begin
                    exp_f = q.pop_front() ^ acc_m;
                    n_cmp++; if (d_f !== exp_f) begin n_bad++; $display("FAIL wrap_out%0d got %h want %h", got, d_f, exp_f); end
                    acc_m = exp_f;
                end
                got++;
            end
            if (d_iv && d_ir) begin
                q.push_back(19'(model_map(32'(cur), 5, 19, 3)));
                sent++;
                cur = 5'($urandom);
            end
        end
        d_iv = 0;
        n_cmp++; if (got !== 17) begin n_bad++; $display("FAIL wrap_out_total got %0d want 17", got); end
        @(negedge clk);
        n_cmp++; if (d_cnt !== 4'd1) begin n_bad++; $display("FAIL wrap_count got %0d want 1", d_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_seq();
        test_backpressure();
        test_reset_mid();
        test_random_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
